softex_red_sum_ctrl: RTL

Sequencer for the FP reduction-sum datapath `softex_fp_red_sum`: accepts one row command (element count, rounding mode) and streams ceil(len/VECT_WIDTH) input vectors into the datapath with per-beat strobes. It tags the final beat and captures the final accumulated result. It then clears the datapath accumulator before accepting the next row. It sits between the softex streamer/control FSM and the reduction datapath.

---
 rtl/softex_red_sum_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/softex_red_sum_ctrl.sv
// softex_red_sum_ctrl: sequencer for the softex FP reduction-sum datapath.
// It accepts one row command (element count, rounding mode) and streams
// ceil(len/VECT_WIDTH) input vectors into the datapath. Each beat carries a lane strobe.
// The final beat is tagged. The tagged (final) datapath result is captured and presented
// on the result handshake. The datapath accumulator is cleared before the next row.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o       row command handshake (cmd_len_i, cmd_mode_i)
//   in_valid_i/in_ready_o         input vector handshake (in_data_i)
//   res_valid_o/res_ready_i       row result handshake (res_o)
//   busy_o                        high whenever the controller is not idle
//   dp_*_o / dp_*_i               datapath stream, control and result return
//
// IN_WIDTH / ACC_WIDTH are the bit widths of the element and accumulator FP formats.
// MODE_WIDTH is the width of the rounding-mode encoding.
module softex_red_sum_ctrl #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned MODE_WIDTH = 3,
    parameter int unsigned VECT_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [LEN_WIDTH-1:0]           cmd_len_i,
    input  logic [MODE_WIDTH-1:0]          cmd_mode_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [VECT_WIDTH*IN_WIDTH-1:0] in_data_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [ACC_WIDTH-1:0]           res_o,
    output logic                           busy_o,
    output logic                           dp_valid_o,
    input  logic                           dp_ready_i,
    output logic [VECT_WIDTH*IN_WIDTH-1:0] dp_vect_o,
    output logic [VECT_WIDTH-1:0]          dp_strb_o,
    output logic                           dp_tag_o,
    output logic [MODE_WIDTH-1:0]          dp_mode_o,
    output logic                           dp_enable_o,
    output logic                           dp_clear_o,
    input  logic                           dp_res_valid_i,
    input  logic [ACC_WIDTH-1:0]           dp_res_i,
    input  logic                           dp_res_tag_i,
    output logic                           dp_res_ready_o
);

    localparam int unsigned LOG_VW    = $clog2(VECT_WIDTH);
    // One extra bit so that the all-ones length rounds up without wrapping.
    localparam int unsigned CNT_WIDTH = LEN_WIDTH - LOG_VW + 1;
    localparam logic [LEN_WIDTH:0] LEN_RND_ADD = (LEN_WIDTH + 1)'(VECT_WIDTH - 1);

    typedef enum logic [2:0] {StInit, StIdle, StStream, StDrain, StOut, StClear} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [LOG_VW-1:0]       tail_q, tail_d;
    logic [MODE_WIDTH-1:0]   mode_q, mode_d;
    logic [ACC_WIDTH-1:0]    res_q, res_d;

    logic [CNT_WIDTH-1:0]    cmd_beats;
    logic                    beat_fire;
    logic                    last_beat;
    logic                    tag_hit;

    assign cmd_beats = CNT_WIDTH'(({1'b0, cmd_len_i} + LEN_RND_ADD) >> LOG_VW);
    assign last_beat = (cnt_q == CNT_WIDTH'(1));
    assign beat_fire = (state_q == StStream) && in_valid_i && dp_ready_i;
    assign tag_hit   = dp_res_valid_i && dp_res_tag_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
            tail_q  <= '0;
            mode_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        mode_d  = mode_q;
        res_d   = res_q;
        unique case (state_q)
            StInit: state_d = StIdle;
            StIdle: begin
                if (cmd_valid_i) begin
                    mode_d = cmd_mode_i;
                    cnt_d  = cmd_beats;
                    tail_d = cmd_len_i[LOG_VW-1:0];
                    if (cmd_len_i == '0) begin
                        res_d   = '0;  // +0.0 in any IEEE-style format
                        state_d = StOut;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (beat_fire) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (last_beat) begin
                        // A zero-latency datapath may return the tagged sum in this cycle.
                        if (tag_hit) begin
                            res_d   = dp_res_i;
                            state_d = StOut;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (tag_hit) begin
                    res_d   = dp_res_i;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (res_ready_i) state_d = StClear;
            end
            StClear: state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready_o    = (state_q == StIdle);
        busy_o         = (state_q != StIdle);
        in_ready_o     = (state_q == StStream) && dp_ready_i;
        dp_valid_o     = (state_q == StStream) && in_valid_i;
        dp_vect_o      = in_data_i;
        dp_tag_o       = (state_q == StStream) && last_beat;
        dp_mode_o      = mode_q;
        dp_enable_o    = (state_q == StStream) || (state_q == StDrain);
        dp_res_ready_o = (state_q == StStream) || (state_q == StDrain);
        dp_clear_o     = (state_q == StInit) || (state_q == StClear);
        res_valid_o    = (state_q == StOut);
        res_o          = res_q;
        dp_strb_o      = '1;
        // Partial last beat: enable only the low `tail` lanes.
        if ((state_q == StStream) && last_beat && (tail_q != '0)) begin
            for (int i = 0; i < VECT_WIDTH; i++) begin
                dp_strb_o[i] = (LOG_VW'(i) < tail_q);
            end
        end
    end

endmodule
